nios2_dmem_resp: RTL and testbench

NIOS2_DMEM_RESP -- requirements
Module: nios2_dmem_resp

---
 rtl/nios2_dmem_pkg.sv | 7 +
 rtl/nios2_dmem_ram.sv | 22 ++
 rtl/nios2_dmem_resp.sv | 78 +++++++
 tb/tb_nios2_dmem_resp.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/nios2_dmem_pkg.sv
// nios2_dmem_pkg: shared state type and size defaults for the data memory responder
package nios2_dmem_pkg;
  typedef enum logic {CLEAR, RUN} state_t;
  localparam int ADDR_W_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam int DATA_W = 32;
endpackage

// File: rtl/nios2_dmem_ram.sv
// nios2_dmem_ram: single write port, synchronous read-before-write read port, no reset
module nios2_dmem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;
  // Read samples the array before the same-edge write lands, so old data is returned
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/nios2_dmem_resp.sv
// nios2_dmem_resp: processor data memory with clear sweep, preload port, error and access counters
module nios2_dmem_resp
  import nios2_dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_mem_wr_i,
  input  logic              data_mem_rd_i,
  input  logic [31:0]       data_mem_addr_i,
  input  logic [31:0]       data_mem_wdata_i,
  output logic [31:0]       data_mem_rdata_o,
  input  logic              ld_wr_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [31:0]       ld_data_i,
  output logic              ld_ack_o,
  output logic              ready_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  rd_cnt_o,
  output logic [CNT_W-1:0]  wr_cnt_o
);
  state_t              state_q;
  logic [ADDR_W-1:0]   clr_q;
  logic                ready_q, err_q, ld_ack_q, rvalid_q;
  logic [CNT_W-1:0]    rd_cnt_q, wr_cnt_q;
  logic                run, addr_ok, rd_ok, wr_ok, ld_ok, ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [DATA_W-1:0]   ram_wdata, ram_rdata;
  assign run     = state_q == RUN;
  assign addr_ok = (data_mem_addr_i >> ADDR_W) == 32'd0;
  assign rd_ok   = run && data_mem_rd_i && addr_ok;
  assign wr_ok   = run && data_mem_wr_i && addr_ok;
  assign ld_ok   = run && ld_wr_i && !data_mem_wr_i;
  // Clear sweep owns the write port; otherwise processor writes win and preload only fills idle slots
  always_comb begin
    ram_we    = !run || wr_ok || ld_ok;
    ram_waddr = !run ? clr_q : wr_ok ? data_mem_addr_i[ADDR_W-1:0] : ld_addr_i;
    ram_wdata = !run ? '0 : wr_ok ? data_mem_wdata_i : ld_data_i;
  end
  nios2_dmem_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk(clk), .we_i(ram_we), .waddr_i(ram_waddr), .wdata_i(ram_wdata),
    .re_i(rd_ok), .raddr_i(data_mem_addr_i[ADDR_W-1:0]), .rdata_o(ram_rdata)
  );
  // CLEAR->RUN sequencing plus registered status; rvalid_q gates RAM data so reset and bad reads show 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CLEAR;
      clr_q    <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      ld_ack_q <= 1'b0;
      rvalid_q <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (!run) begin
        clr_q <= clr_q + ADDR_W'(1);
        if (clr_q == '1) begin
          state_q <= RUN;
          ready_q <= 1'b1;
        end
      end
      if ((data_mem_rd_i || data_mem_wr_i) && (!run || !addr_ok)) err_q <= 1'b1;
      ld_ack_q <= ld_ok;
      if (run && data_mem_rd_i) rvalid_q <= addr_ok;
      if (rd_ok && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      if (wr_ok && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
    end
  end
  assign data_mem_rdata_o = rvalid_q ? ram_rdata : '0;
  assign ld_ack_o = ld_ack_q;
  assign ready_o  = ready_q;
  assign err_o    = err_q;
  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
endmodule

// File: tb/tb_nios2_dmem_resp.sv
// tb_nios2_dmem_resp: randomized scoreboard bench for the data memory responder
module tb_nios2_dmem_resp;
  logic clk = 0, rst = 1;
  logic rd = 0, wr = 0, ld = 0;
  logic [31:0] addr = 0, wdata = 0, ld_data = 0, rdata;
  logic [7:0] ld_addr = 0;
  logic ld_ack, ready, err;
  logic [15:0] rd_cnt, wr_cnt;
  logic s_rd = 0, s_wr = 0, s_ld = 0;
  logic [31:0] s_addr = 0, s_wdata = 0, s_rdata;
  logic [1:0] s_ld_addr = 0, s_rd_cnt, s_wr_cnt;
  logic s_ld_ack, s_ready, s_err;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  nios2_dmem_resp dut (
    .clk(clk), .rst(rst), .data_mem_wr_i(wr), .data_mem_rd_i(rd), .data_mem_addr_i(addr),
    .data_mem_wdata_i(wdata), .data_mem_rdata_o(rdata), .ld_wr_i(ld), .ld_addr_i(ld_addr),
    .ld_data_i(ld_data), .ld_ack_o(ld_ack), .ready_o(ready), .err_o(err),
    .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
  );

  nios2_dmem_resp #(.ADDR_W(2), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .data_mem_wr_i(s_wr), .data_mem_rd_i(s_rd), .data_mem_addr_i(s_addr),
    .data_mem_wdata_i(s_wdata), .data_mem_rdata_o(s_rdata), .ld_wr_i(s_ld), .ld_addr_i(s_ld_addr),
    .ld_data_i(32'd0), .ld_ack_o(s_ld_ack), .ready_o(s_ready), .err_o(s_err),
    .rd_cnt_o(s_rd_cnt), .wr_cnt_o(s_wr_cnt)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [15:0] rd_cnt, wr_cnt;
    logic err, ack;
  } exp_t;
  exp_t sbq[$];
  exp_t e;
  logic [31:0] mem [256];
  logic [31:0] m_rdata;
  logic [15:0] m_rd, m_wr;
  logic m_err;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset(input logic keep_err);
    foreach (mem[i]) mem[i] = 0;
    m_rdata = 0; m_rd = 0; m_wr = 0; m_err = keep_err;
  endtask

  // One RUN-state cycle: apply inputs, predict the state after the next edge
  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic l, input logic [7:0] la, input logic [31:0] ld_d);
    logic ok;
    exp_t x;
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = wd; ld = l; ld_addr = la; ld_data = ld_d;
    ok = (a >> 8) == 0;
    if (r) begin
      m_rdata = ok ? mem[a[7:0]] : 32'd0;
      if (ok && m_rd != 16'hffff) m_rd++;
    end
    if ((r || w) && !ok) m_err = 1;
    if (w && ok) begin
      mem[a[7:0]] = wd;
      if (m_wr != 16'hffff) m_wr++;
    end
    if (l && !w) mem[la] = ld_d;
    x.rdata = m_rdata; x.rd_cnt = m_rd; x.wr_cnt = m_wr; x.err = m_err; x.ack = l && !w;
    sbq.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: after each edge, compare the DUT against the oldest prediction
  always @(posedge clk) begin
    #1;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("rdata", rdata, e.rdata);
      chk("rd_cnt", 32'(rd_cnt), 32'(e.rd_cnt));
      chk("wr_cnt", 32'(wr_cnt), 32'(e.wr_cnt));
      chk("err", 32'(err), 32'(e.err));
      chk("ld_ack", 32'(ld_ack), 32'(e.ack));
      chk("ready", 32'(ready), 32'd1);
    end
  end

  task automatic chk_zero(input string n);
    chk({n, "_rdata"}, rdata, 0);
    chk({n, "_ack"}, 32'(ld_ack), 0);
    chk({n, "_ready"}, 32'(ready), 0);
    chk({n, "_err"}, 32'(err), 0);
    chk({n, "_rdcnt"}, 32'(rd_cnt), 0);
    chk({n, "_wrcnt"}, 32'(wr_cnt), 0);
  endtask

  // Release reset and count edges until ready; optionally poke dropped requests in the first cycle
  task automatic run_clear(input string n, input logic poke);
    int cyc = 0;
    int acks = 0;
    @(negedge clk);
    rst = 0;
    if (poke) begin rd = 1; addr = 3; ld = 1; ld_addr = 8'h07; ld_data = 32'h12345678; end
    while (cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (poke) begin rd = 0; ld = 0; end
      if (ld_ack) acks++;
      if (ready) break;
    end
    chk({n, "_cycles"}, cyc, 256);
    chk({n, "_acks"}, acks, 0);
  endtask

  initial begin
    model_reset(0);
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    run_clear("clear1", 0);
    drive(1, 0, 32'h82, 0, 0, 0, 0);
    drive(0, 1, 32'h82, 32'h9, 0, 0, 0);
    drive(1, 0, 32'h82, 0, 0, 0, 0);
    drive(0, 1, 32'h10, 32'h11, 0, 0, 0);
    drive(1, 1, 32'h10, 32'h22, 0, 0, 0);
    drive(1, 0, 32'h10, 0, 0, 0, 0);
    drive(0, 1, 32'h100, 32'h55, 0, 0, 0);
    drive(1, 0, 32'h100, 0, 0, 0, 0);
    drive(1, 0, 32'h0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 32'h20, 32'h20 + i, 1, 8'h05, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 1, 8'h05, 32'hDEADBEEF);
    drive(1, 0, 32'h05, 0, 0, 0, 0);
    drive(1, 0, 32'h06, 0, 1, 8'h06, 32'hCAFEF00D);
    drive(1, 0, 32'h06, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? 32'h100 << $urandom_range(0, 23) : 32'($urandom_range(0, 15));
      drive(1'($urandom), 1'($urandom), a, $urandom, $urandom_range(0, 3) == 0,
            8'($urandom_range(0, 15)), $urandom);
    end
    idle(2);
    @(negedge clk);
    // Narrow instance: counters saturate at 3 without wrapping
    for (int i = 0; i < 6; i++) begin
      s_rd = 1; s_wr = 1; s_addr = 1; s_wdata = i;
      @(negedge clk);
    end
    s_rd = 1; s_wr = 0;
    @(negedge clk);
    s_rd = 0;
    chk("sat_rd", 32'(s_rd_cnt), 3);
    chk("sat_wr", 32'(s_wr_cnt), 3);
    chk("sat_rdata", s_rdata, 5);
    chk("sat_err", 32'(s_err), 0);
    rst = 1;
    #1;
    chk_zero("rst_run");
    run_clear("clear2", 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    repeat (100) @(posedge clk);
    #2;
    chk("mid_ready_before", 32'(ready), 0);
    rst = 1;
    #1;
    chk_zero("rst_mid");
    model_reset(1);
    run_clear("clear3", 1);
    chk("drop_err", 32'(err), 1);
    drive(1, 0, 32'h07, 0, 0, 0, 0);
    drive(1, 0, 32'h03, 0, 0, 0, 0);
    drive(1, 0, 32'h05, 0, 0, 0, 0);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=done");
    $fatal(1, "timeout");
  end
endmodule
